// File: rtl/seq_sub_pkg.sv
// Shared definitions for the sequential chunked subtractor.
package seq_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for n slices, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_subtractor_sub_chunk.sv
// One CHUNK-bit slice of a ripple subtractor: diff = a - b - borrow_in.
module sub_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_borrow_in,
    output logic [CHUNK-1:0] o_diff,
    output logic             o_borrow_out
);

    logic [CHUNK:0] w_full;

    assign w_full       = {1'b0, i_a} - {1'b0, i_b} - {{CHUNK{1'b0}}, i_borrow_in};
    assign o_diff       = w_full[CHUNK-1:0];
    assign o_borrow_out = w_full[CHUNK];

endmodule

// File: rtl/seq_subtractor.sv
// Multi-cycle subtractor, one CHUNK-bit slice per cycle, valid/ready on both sides.
// Optional macro SEQ_SUBTRACTOR_SAT_EN clamps a negative result to zero.
module seq_subtractor
    import seq_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("seq_subtractor: WIDTH must be a multiple of CHUNK");
    end

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_work;
    logic             r_bin;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic [CHUNK-1:0]       w_dslice;
    logic                   w_bout;
    logic [WIDTH+CHUNK-1:0] w_cat;
    logic [WIDTH-1:0]       w_next_work;

    sub_chunk #(.CHUNK(CHUNK)) u_sub_chunk (
        .i_a          (r_a[CHUNK-1:0]),
        .i_b          (r_b[CHUNK-1:0]),
        .i_borrow_in  (r_bin),
        .o_diff       (w_dslice),
        .o_borrow_out (w_bout)
    );

    // Operands shift right so the active slice is always at the bottom; the
    // result shifts in from the top and is fully aligned after N slices.
    assign w_cat       = {w_dslice, r_work};
    assign w_next_work = w_cat[WIDTH+CHUNK-1:CHUNK];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_bin    <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_bin   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_a    <= r_a >> CHUNK;
                    r_b    <= r_b >> CHUNK;
                    r_work <= w_next_work;
                    r_bin  <= w_bout;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_borrow <= w_bout;
`ifdef SEQ_SUBTRACTOR_SAT_EN
                        r_diff   <= w_bout ? '0 : w_next_work;
`else
                        r_diff   <= w_next_work;
`endif
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign diff      = r_diff;
    assign borrow    = r_borrow;

endmodule

// File: tb/tb_seq_subtractor.sv
// Directed + randomized bench for seq_subtractor (WIDTH=8, CHUNK=4).
module tb_seq_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borrow;

    int n_tests = 0;
    int n_fail  = 0;

    seq_subtractor #(.WIDTH(8), .CHUNK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned difference modulo 256, borrow when x < y.
    function automatic logic [8:0] model(input logic [7:0] x, input logic [7:0] y);
        int   d;
        logic br;
        br = (x < y);
        d  = (int'(x) - int'(y) + 256) % 256;
`ifdef SEQ_SUBTRACTOR_SAT_EN
        if (br) d = 0;
`endif
        return {br, 8'(d)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          input int hold, input bit perturb);
        logic [8:0] exp;
        int         lat;
        exp       = model(x, y);
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        check("in_ready_idle", in_ready, 1);
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (perturb) begin
                a        = 8'($urandom);
                b        = 8'($urandom);
                in_valid = 1'b1;
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, 2);
        check("diff", diff, exp[7:0]);
        check("borrow", borrow, exp[8]);
        check("in_ready_done", in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_diff", diff, exp[7:0]);
            check("hold_borrow", borrow, exp[8]);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("released_valid", out_valid, 0);
        check("released_in_ready", in_ready, 1);
        check("idle_diff_held", diff, exp[7:0]);
        check("idle_borrow_held", borrow, exp[8]);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow, 0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", in_ready, 1);

        run_op(8'd5, 8'd3, 0, 1'b0);
        run_op(8'd0, 8'd1, 0, 1'b0);
        run_op(8'd200, 8'd200, 0, 1'b0);
        run_op(8'h10, 8'h01, 0, 1'b0);
        run_op(8'd37, 8'd180, 5, 1'b0);
        run_op(8'd99, 8'd42, 0, 1'b1);

        // Reset one cycle into BUSY must discard the operation.
        a        = 8'd150;
        b        = 8'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow, 0);
        check("abort_in_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_no_stale", out_valid, 0);
        end

        for (int i = 0; i < 30; i++) begin
            run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
